// File: rtl/multu_hilo.sv
// multu_hilo: sequential unsigned shift-add multiplier feeding a HI/LO register pair.
// One partial-product step per clock while MULTU is held; the product is committed
// into HI/LO on the HILO_WR code and read back through MFHI/MFLO.
module multu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] SIG_MULTU   = 6'd25;
  localparam logic [5:0] SIG_MFHI    = 6'd16;
  localparam logic [5:0] SIG_MFLO    = 6'd18;
  localparam logic [5:0] SIG_HILO_WR = 6'b111111;
  localparam logic [5:0] LAST_STEP   = 6'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_prod;

  // One shift-add step: add the multiplicand into the upper half when the current
  // multiplier bit is set, keeping the carry so the 65-bit shift loses nothing.
  always_comb begin
    step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
    if (prod_q[0]) begin
      step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    step_prod = {step_sum, prod_q[WIDTH-1:1]};
  end

  // Next-state and datapath update; a write arriving on the final step commits
  // the freshly stepped product directly and skips DONE.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (Signal == SIG_MULTU) begin
          mcand_d = dataA;
          prod_d  = {{WIDTH{1'b0}}, dataB};
          cnt_d   = 6'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (Signal == SIG_MULTU || Signal == SIG_HILO_WR) begin
          prod_d = step_prod;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            if (Signal == SIG_HILO_WR) begin
              hi_d    = step_prod[2*WIDTH-1:WIDTH];
              lo_d    = step_prod[WIDTH-1:0];
              state_d = IDLE;
            end else begin
              state_d = DONE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (Signal == SIG_HILO_WR) begin
          hi_d    = prod_q[2*WIDTH-1:WIDTH];
          lo_d    = prod_q[WIDTH-1:0];
          state_d = IDLE;
        end else if (Signal != SIG_MULTU) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Read port and status decodes; reads are combinational from HI/LO.
  always_comb begin
    dataOut = '0;
    if (Signal == SIG_MFHI) begin
      dataOut = hi_q;
    end else if (Signal == SIG_MFLO) begin
      dataOut = lo_q;
    end
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo: directed self-checking bench for multu_hilo.
module tb_multu_hilo;

  localparam logic [5:0] MULTU   = 6'd25;
  localparam logic [5:0] MFHI    = 6'd16;
  localparam logic [5:0] MFLO    = 6'd18;
  localparam logic [5:0] HILO_WR = 6'b111111;
  localparam logic [5:0] ADD     = 6'd32;
  localparam logic [5:0] NOP     = 6'd0;

  logic        clk;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  multu_hilo #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one active edge; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a multiply, hold MULTU through all steps plus wait_cycles in DONE, then write.
  task automatic do_multiply(input logic [31:0] a, input logic [31:0] b, input int wait_cycles);
    Signal = MULTU;
    dataA  = a;
    dataB  = b;
    tick();
    repeat (32) tick();
    repeat (wait_cycles) tick();
    Signal = HILO_WR;
    tick();
    Signal = NOP;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    Signal = MFHI;
    dataA  = '0;
    dataB  = '0;
    tick();
    tick();
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_status busy=%b done=%b expected 0 0", busy, done);
    end
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL reset_mfhi got %h expected 00000000", dataOut);
    end
    reset = 1'b1;
    Signal = NOP;
    tick();
  endtask

  task automatic test_basic();
    Signal = MULTU;
    dataA  = 32'd3;
    dataB  = 32'd5;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL basic_start busy=%b done=%b expected 1 0", busy, done);
    end
    repeat (31) tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL basic_step31 busy=%b done=%b expected 1 0", busy, done);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL basic_step32 busy=%b done=%b expected 0 1", busy, done);
    end
    Signal = HILO_WR;
    tick();
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd15) begin
      n_err++;
      $display("[TB] FAIL basic_lo got %h expected 0000000f", dataOut);
    end
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL basic_hi got %h expected 00000000", dataOut);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL basic_idle busy=%b done=%b expected 0 0", busy, done);
    end
    Signal = NOP;
    tick();
  endtask

  task automatic test_simultaneous();
    int done_seen;
    done_seen = 0;
    Signal = MULTU;
    dataA  = 32'hFFFF_FFFF;
    dataB  = 32'hFFFF_FFFF;
    tick();
    for (int i = 0; i < 31; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    Signal = HILO_WR;
    tick();
    if (done === 1'b1) done_seen++;
    n_cmp++;
    if (done_seen != 0) begin
      n_err++;
      $display("[TB] FAIL simul_done_never got %0d high cycles expected 0", done_seen);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL simul_idle busy=%b done=%b expected 0 0", busy, done);
    end
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("[TB] FAIL simul_hi got %h expected fffffffe", dataOut);
    end
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'h0000_0001) begin
      n_err++;
      $display("[TB] FAIL simul_lo got %h expected 00000001", dataOut);
    end
    Signal = NOP;
    tick();
  endtask

  task automatic test_late_commit();
    int done_low;
    done_low = 0;
    Signal = MULTU;
    dataA  = 32'h8000_0000;
    dataB  = 32'd2;
    tick();
    repeat (32) tick();
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b1 || busy !== 1'b0) done_low++;
      tick();
    end
    n_cmp++;
    if (done_low != 0) begin
      n_err++;
      $display("[TB] FAIL late_done_hold got %0d bad cycles expected 0", done_low);
    end
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("[TB] FAIL late_hi_before_commit got %h expected fffffffe", dataOut);
    end
    Signal = MULTU;
    #1;
    Signal = HILO_WR;
    tick();
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'd1) begin
      n_err++;
      $display("[TB] FAIL late_hi got %h expected 00000001", dataOut);
    end
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL late_lo got %h expected 00000000", dataOut);
    end
    Signal = NOP;
    tick();
  endtask

  task automatic test_idle_write_abort();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    Signal = HILO_WR;
    dataA = 32'd7;
    dataB = 32'd6;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL idle_write_state busy=%b done=%b expected 0 0", busy, done);
    end
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL idle_write_lo got %h expected 00000000", dataOut);
    end
    Signal = MULTU;
    tick();
    repeat (9) tick();
    Signal = ADD;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL abort_state busy=%b done=%b expected 0 0", busy, done);
    end
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL abort_lo got %h expected 00000000", dataOut);
    end
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL abort_hi got %h expected 00000000", dataOut);
    end
    Signal = NOP;
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_multiply(32'd3, 32'd5, 0);
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd15) begin
      n_err++;
      $display("[TB] FAIL midrst_prior_lo got %h expected 0000000f", dataOut);
    end
    Signal = MULTU;
    dataA  = 32'h1234_5678;
    dataB  = 32'h9ABC_DEF0;
    tick();
    repeat (19) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_state busy=%b done=%b expected 0 0", busy, done);
    end
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL midrst_lo got %h expected 00000000", dataOut);
    end
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL midrst_hi got %h expected 00000000", dataOut);
    end
    Signal = NOP;
    tick();
  endtask

  task automatic test_back_to_back();
    do_multiply(32'd3, 32'd5, 0);
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd15) begin
      n_err++;
      $display("[TB] FAIL b2b_first_lo got %h expected 0000000f", dataOut);
    end
    Signal = MULTU;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL b2b_other_code_read got %h expected 00000000", dataOut);
    end
    do_multiply(32'd10, 32'd10, 2);
    Signal = MFLO;
    #1;
    n_cmp++;
    if (dataOut !== 32'd100) begin
      n_err++;
      $display("[TB] FAIL b2b_second_lo got %h expected 00000064", dataOut);
    end
    Signal = MFHI;
    #1;
    n_cmp++;
    if (dataOut !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL b2b_second_hi got %h expected 00000000", dataOut);
    end
    Signal = NOP;
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    Signal = NOP;
    dataA  = '0;
    dataB  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_simultaneous();
    test_late_commit();
    test_idle_write_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32x32 unsigned shift-add multiplier with the HI/LO register pair. It is the receiving end of the ALU control unit's multiplier signal (`SignaltoMUL`). The block starts a multiply when it sees the MULTU code and runs one partial-product step per clock. It commits the 64-bit product into HI/LO when the control unit raises the HI/LO write code, and returns HI or LO on MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width; the product is 2*WIDTH. Only 32 is required and verified.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low reset.
- `Signal` input 6: control code from the ALU control unit. MULTU=25, MFHI=16, MFLO=18, HILO_WR=6'b111111. All other codes are ignored.
- `dataA` input 32: multiplicand. Sampled only on the start edge.
- `dataB` input 32: multiplier. Sampled only on the start edge.
- `dataOut` output 32: read data. HI when `Signal`==MFHI, LO when MFLO, otherwise 0. Combinational from the HI/LO registers.
- `busy` output 1: high while in RUN.
- `done` output 1: high while in DONE (product valid, not yet committed).

## Operation
- Registers:
  - `mcand` (32)
  - `prod` (64): upper half accumulates, lower half holds the multiplier
  - `cnt` (6)
  - `HI` and `LO` (32 each)
  - `state` ∈ {IDLE, RUN, DONE}
- IDLE:
  - On an edge with `Signal`==MULTU: `mcand`←`dataA`, `prod`←{32'b0,`dataB`}, `cnt`←0, go to RUN.
  - HILO_WR in IDLE is ignored. HI/LO are unchanged.
- RUN, every edge:
  - If `prod[0]`, the sum = {1'b0,`prod[63:32]`}+{1'b0,`mcand`} (33 bits, carry kept). Otherwise the sum = {1'b0,`prod[63:32]`}.
  - `prod`←{sum,`prod[31:1]`}. This is a 65-bit value shifted right by one.
  - `cnt`←`cnt`+1. After the edge with `cnt`==31 (the 32nd step), go to DONE.
- RUN abort:
  - If `Signal` is neither MULTU nor HILO_WR on a RUN edge, go to IDLE with no step taken.
  - HI/LO are unchanged.
- DONE:
  - On HILO_WR: HI←`prod[63:32]`, LO←`prod[31:0]`, go to IDLE.
  - On MULTU: stay in DONE and keep holding the product.
  - On any other code: go to IDLE and discard the product.
- Simultaneous final step and write: if HILO_WR arrives on the RUN edge with `cnt`==31, HI/LO take the result of that final step, and the state goes to IDLE, not DONE.
- Restart: if MULTU is still present in IDLE after a commit, a new multiply starts on the next edge. HI/LO keep the committed value until the next HILO_WR.
- No signed mode. Overflow cannot occur because the 64-bit product always fits.

## Timing
- Reset: on a clock edge with `reset`==0, all of the following take effect:
  - state=IDLE, HI=0, LO=0, `prod`=0, `mcand`=0, `cnt`=0
  - `busy`=0, `done`=0
  - `dataOut`=0 regardless of `Signal`
- Reset mid-RUN or in DONE aborts immediately and clears HI/LO.
- Latency:
  - Start edge E0.
  - Steps on E1..E32.
  - The product is valid in `prod` after E32.
  - The earliest HI/LO commit is on E32 (simultaneous case). Otherwise commit is on the first HILO_WR edge after E32.
- The ALU control unit holds MULTU for the whole run and then raises HILO_WR for exactly one cycle. The block must commit correctly whether that cycle lands on E32 or later.
- `dataOut` has zero-cycle latency from `Signal` and HI/LO. A read in the cycle after a commit edge returns the new value.
- `busy` and `done` are registered state decodes. They are never high together.

## Test plan
- Reset, then MULTU with A=3, B=5, held 32 cycles, then HILO_WR, then MFLO and MFHI. Required: `dataOut`=15, then 0.
- A=B=0xFFFFFFFF, with HILO_WR on the E32 edge (simultaneous case). Required: HI=0xFFFFFFFE, LO=0x00000001, state IDLE, `done` never high.
- A=0x80000000, B=2, with HILO_WR held off 5 cycles after E32. Required: `done` high for those cycles, then HI=1, LO=0.
- HILO_WR in IDLE before any multiply. Required: HI=LO=0. Then MULTU 7x6 is aborted at step 10 by `Signal`=ADD (32). Required: state IDLE, HI/LO still 0, `busy` low next cycle.
- `reset`=0 asserted at step 20 of 0x12345678 x 0x9ABCDEF0, after a prior commit of 3x5. Required: next cycle HI=LO=0, `busy`=0, MFLO reads 0.
- Back-to-back: commit 3x5, then MULTU held with new operands 10x10, then HILO_WR. Required: LO=15 until the second commit, then LO=100, HI=0.
